// File: rtl/obstacle_stream_gen_if.sv
// Request, table-write and row-output bundle of the obstacle row generator.
// AW must equal $clog2(DEPTH) of the generator this interface is bound to.
interface obstacle_stream_gen_if #(
    parameter int LANES = 7,
    parameter int AW    = 4
);
    logic             en;
    logic             mode;
    logic             step;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [LANES-1:0] wr_data;
    logic             out_valid;
    logic             out_ready;
    logic [LANES-1:0] out_row;
    logic             out_bonus;
    logic [AW-1:0]    out_idx;

    modport master (
        output en, mode, step, wr_en, wr_addr, wr_data, out_ready,
        input  out_valid, out_row, out_bonus, out_idx
    );
    modport slave (
        input  en, mode, step, wr_en, wr_addr, wr_data, out_ready,
        output out_valid, out_row, out_bonus, out_idx
    );
endinterface

// File: rtl/obstacle_stream_gen.sv
// Obstacle row generator: pattern table, sequential or LFSR index selection,
// periodic all-lanes bonus rows, one row per accepted step over valid/ready.
module obstacle_stream_gen #(
    parameter int          LANES        = 7,
    parameter int          DEPTH        = 16,
    parameter int          BONUS_PERIOD = 17,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    localparam int         AW           = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    obstacle_stream_gen_if.slave bus
);
    localparam int BCW = (BONUS_PERIOD > 1) ? $clog2(BONUS_PERIOD) : 1;

    logic [LANES-1:0] tbl [DEPTH];
    logic             pending;
    logic [AW-1:0]    seq;
    logic [AW-1:0]    prev;
    logic [BCW-1:0]   bcnt;
    logic [15:0]      lfsr;

    logic             req, gen, is_bonus;
    logic [15:0]      lfsr_nxt;
    logic [AW-1:0]    cand, idx;

    // A step in the same cycle as a free output generates directly (latency 1)
    assign req      = bus.en & (pending | bus.step);
    assign gen      = req & (!bus.out_valid | bus.out_ready);
    assign is_bonus = (BONUS_PERIOD != 0) && (bcnt == BCW'(BONUS_PERIOD - 1));

    // Right-shift Galois form of x^16+x^14+x^13+x^11+1
    assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign cand     = lfsr_nxt[AW-1:0];
    assign idx      = bus.mode ? ((cand == prev) ? cand + AW'(1) : cand) : seq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                tbl[i] <= LANES'(1) << (i % LANES);
            pending       <= 1'b0;
            seq           <= '0;
            prev          <= '0;
            bcnt          <= '0;
            lfsr          <= LFSR_SEED;
            bus.out_valid <= 1'b0;
            bus.out_row   <= '0;
            bus.out_bonus <= 1'b0;
            bus.out_idx   <= '0;
        end else begin
            // Read below samples the pre-write contents, so a same-address write lands next cycle
            if (bus.wr_en)
                tbl[bus.wr_addr] <= bus.wr_data;

            // Extra steps while a request is outstanding merge into it
            if (bus.en)
                pending <= (pending | bus.step) & !gen;

            if (gen) begin
                bus.out_valid <= 1'b1;
                if (BONUS_PERIOD != 0)
                    bcnt <= is_bonus ? '0 : bcnt + BCW'(1);
                if (is_bonus) begin
                    bus.out_row   <= '1;
                    bus.out_bonus <= 1'b1;
                    bus.out_idx   <= '0;
                end else begin
                    bus.out_row   <= tbl[idx];
                    bus.out_bonus <= 1'b0;
                    bus.out_idx   <= idx;
                    prev          <= idx;
                    if (bus.mode)
                        lfsr <= lfsr_nxt;
                    else
                        seq <= seq + AW'(1);
                end
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_obstacle_stream_gen.sv
// Directed bench: dut_a has bonus disabled, dut_b uses BONUS_PERIOD=17; both see the same stimulus.
module tb_obstacle_stream_gen;
    localparam int LANES = 7;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    obstacle_stream_gen_if #(.LANES(LANES), .AW(AW)) bus_a ();
    obstacle_stream_gen_if #(.LANES(LANES), .AW(AW)) bus_b ();

    obstacle_stream_gen #(.LANES(LANES), .DEPTH(DEPTH), .BONUS_PERIOD(0), .LFSR_SEED(16'hACE1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    obstacle_stream_gen #(.LANES(LANES), .DEPTH(DEPTH), .BONUS_PERIOD(17), .LFSR_SEED(16'hACE1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    assign bus_b.en        = bus_a.en;
    assign bus_b.mode      = bus_a.mode;
    assign bus_b.step      = bus_a.step;
    assign bus_b.wr_en     = bus_a.wr_en;
    assign bus_b.wr_addr   = bus_a.wr_addr;
    assign bus_b.wr_data   = bus_a.wr_data;
    assign bus_b.out_ready = bus_a.out_ready;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic step_a();
        bus_a.step = 1'b1;
        cyc();
        bus_a.step = 1'b0;
    endtask

    function automatic logic [LANES-1:0] dflt(input int i);
        logic [LANES-1:0] one;
        one = LANES'(1);
        return one << (i % LANES);
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_a_valid"}, 32'(bus_a.out_valid), 32'd0);
        chk({tag, "_a_row"},   32'(bus_a.out_row),   32'd0);
        chk({tag, "_a_bonus"}, 32'(bus_a.out_bonus), 32'd0);
        chk({tag, "_a_idx"},   32'(bus_a.out_idx),   32'd0);
        chk({tag, "_b_valid"}, 32'(bus_b.out_valid), 32'd0);
        chk({tag, "_b_row"},   32'(bus_b.out_row),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [LANES-1:0] tbl [DEPTH];
        logic [15:0]      lfsr;
        logic [AW-1:0]    prev, cand, eidx, last;
        int               i;

        bus_a.en = 1'b1; bus_a.mode = 1'b0; bus_a.step = 1'b0;
        bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
        bus_a.out_ready = 1'b1;

        #12;
        chk_zero("reset");
        rst_n = 1'b1;
        cyc();

        // T1: sequential rows 0..3, each visible one edge after its step
        chk("t1_idle_valid", 32'(bus_a.out_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step_a();
            chk("t1_valid", 32'(bus_a.out_valid), 32'd1);
            chk("t1_row",   32'(bus_a.out_row),   32'(dflt(k)));
            chk("t1_idx",   32'(bus_a.out_idx),   32'(k));
            chk("t1_bonus", 32'(bus_a.out_bonus), 32'd0);
        end

        // T2: walk to 15, then wrap; dut_b emits the bonus row as its 17th
        for (int k = 4; k < 16; k++) begin
            step_a();
            chk("t2_a_idx", 32'(bus_a.out_idx), 32'(k));
            chk("t2_b_idx", 32'(bus_b.out_idx), 32'(k));
        end
        step_a();
        chk("t2_a_wrap_idx", 32'(bus_a.out_idx),   32'd0);
        chk("t2_a_wrap_row", 32'(bus_a.out_row),   32'h01);
        chk("t2_b_bonus",    32'(bus_b.out_bonus), 32'd1);
        chk("t2_b_bonus_row",32'(bus_b.out_row),   32'h7f);
        chk("t2_b_bonus_idx",32'(bus_b.out_idx),   32'd0);
        step_a();
        chk("t2_a_idx1",     32'(bus_a.out_idx),   32'd1);
        chk("t2_b_after",    32'(bus_b.out_idx),   32'd0);
        chk("t2_b_after_bn", 32'(bus_b.out_bonus), 32'd0);
        chk("t2_b_after_row",32'(bus_b.out_row),   32'h01);

        // T3: backpressure holds the row, pending request fills the slot with no bubble
        cyc();
        chk("t3_drained", 32'(bus_a.out_valid), 32'd0);
        bus_a.out_ready = 1'b0;
        step_a();
        chk("t3_first_idx", 32'(bus_a.out_idx), 32'd2);
        step_a();
        cyc(); cyc();
        chk("t3_hold_valid", 32'(bus_a.out_valid), 32'd1);
        chk("t3_hold_row",   32'(bus_a.out_row),   32'h04);
        chk("t3_hold_idx",   32'(bus_a.out_idx),   32'd2);
        bus_a.out_ready = 1'b1;
        cyc();
        chk("t3_nobubble_valid", 32'(bus_a.out_valid), 32'd1);
        chk("t3_next_row",       32'(bus_a.out_row),   32'h08);
        chk("t3_next_idx",       32'(bus_a.out_idx),   32'd3);
        cyc();
        chk("t3_empty", 32'(bus_a.out_valid), 32'd0);

        // step with en low is ignored and leaves nothing pending
        bus_a.en = 1'b0;
        step_a();
        chk("en_off_valid", 32'(bus_a.out_valid), 32'd0);
        bus_a.en = 1'b1;
        cyc();
        chk("en_off_nopend", 32'(bus_a.out_valid), 32'd0);

        // T4: write entry 5 in the same cycle it is read -> old contents first
        step_a();
        chk("t4_idx4", 32'(bus_a.out_row), 32'h10);
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 4'd5; bus_a.wr_data = 7'b1010101;
        step_a();
        bus_a.wr_en = 1'b0;
        chk("t4_old_row", 32'(bus_a.out_row), 32'h20);
        chk("t4_old_idx", 32'(bus_a.out_idx), 32'd5);
        for (int k = 6; k < 21; k++) begin
            step_a();
            chk("t4_walk_idx", 32'(bus_a.out_idx), 32'(k % 16));
            chk("t4_walk_row", 32'(bus_a.out_row), 32'(dflt(k % 16)));
        end
        step_a();
        chk("t4_new_row", 32'(bus_a.out_row), 32'h55);
        chk("t4_new_idx", 32'(bus_a.out_idx), 32'd5);

        // T5: 200 random rows against a reference LFSR model
        for (int k = 0; k < DEPTH; k++) tbl[k] = dflt(k);
        tbl[5] = 7'b1010101;
        lfsr = 16'hACE1;
        prev = 4'd5;
        last = 4'd5;
        bus_a.mode = 1'b1;
        for (i = 0; i < 200; i++) begin
            lfsr = lfsr_step(lfsr);
            cand = lfsr[AW-1:0];
            eidx = (cand == prev) ? cand + 4'd1 : cand;
            prev = eidx;
            step_a();
            chk("t5_idx",      32'(bus_a.out_idx),         32'(eidx));
            chk("t5_row",      32'(bus_a.out_row),         32'(tbl[eidx]));
            chk("t5_distinct", 32'(bus_a.out_idx != last), 32'd1);
            last = bus_a.out_idx;
        end

        // T6: async reset with a held row and a pending request
        bus_a.mode = 1'b0;
        bus_a.out_ready = 1'b0;
        step_a();
        step_a();
        chk("t6_pre_valid", 32'(bus_a.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("t6_rst");
        cyc();
        rst_n = 1'b1;
        bus_a.out_ready = 1'b1;
        cyc();
        chk("t6_no_pending", 32'(bus_a.out_valid), 32'd0);
        step_a();
        chk("t6_seq_idx", 32'(bus_a.out_idx), 32'd0);
        chk("t6_seq_row", 32'(bus_a.out_row), 32'h01);
        bus_a.mode = 1'b1;
        step_a();
        // seed 0xACE1 -> 0xE270, cand 0 collides with prev 0 -> idx 1
        chk("t6_rand_idx",   32'(bus_a.out_idx), 32'd1);
        chk("t6_rand_row",   32'(bus_a.out_row), 32'h02);
        chk("t6_b_rand_idx", 32'(bus_b.out_idx), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
